// File: rtl/ahb_uart_if.sv
// AHB-Lite slave-side bus bundle for the console UART.
// The master modport drives the address/data phase; the slave answers with ready, data and response.
interface ahb_uart_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_uart.sv
// AHB-Lite UART: 4-entry TX FIFO feeding an 8N1 serialiser, single-byte RX holding register,
// sticky status flags and a programmable clocks-per-bit divisor.
module ahb_uart #(
  parameter int DEFAULT_DIV = 16,
  parameter int TX_DEPTH    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  ahb_uart_if.slave  bus,
  output logic       TXD,
  input  logic       RXD,
  output logic       IRQ
);
  localparam int AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- bus address/data phase ----------------
  logic       valid_reg, write_reg;
  logic [1:0] addr_reg;
  logic       dphase, wr_data, wr_status, wr_baud, rd_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_reg <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= 2'd0;
    end else if (bus.HREADY) begin
      valid_reg <= bus.HSEL & bus.HTRANS[1];
      write_reg <= bus.HWRITE;
      addr_reg  <= bus.HADDR[3:2];
    end
  end

  assign dphase    = valid_reg & bus.HREADY;
  assign wr_data   = dphase & write_reg  & (addr_reg == 2'd0);
  assign wr_status = dphase & write_reg  & (addr_reg == 2'd1);
  assign wr_baud   = dphase & write_reg  & (addr_reg == 2'd2);
  assign rd_data   = dphase & ~write_reg & (addr_reg == 2'd0);

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:16]};

  // ---------------- control registers ----------------
  logic [15:0] baud_reg;
  logic        tx_ie_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_reg  <= 16'(DEFAULT_DIV);
      tx_ie_reg <= 1'b0;
    end else begin
      if (wr_status) tx_ie_reg <= bus.HWDATA[8];
      // Dividers below 4 would leave no room for the half-bit RX start sample.
      if (wr_baud)   baud_reg  <= (bus.HWDATA[15:0] < 16'd4) ? 16'd4 : bus.HWDATA[15:0];
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        fifo_empty, fifo_full, push, tx_pop, tx_drop_reg;
  logic [7:0]  fifo_head;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push       = wr_data & ~fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= bus.HWDATA[7:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      tx_drop_reg <= 1'b0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (tx_pop) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      if (wr_status && bus.HWDATA[5]) tx_drop_reg <= 1'b0;
      if (wr_data && fifo_full)       tx_drop_reg <= 1'b1;
    end
  end

  // ---------------- TX serialiser ----------------
  state_t      tx_state_reg;
  logic [15:0] tx_cnt_reg, tx_div_reg;
  logic [2:0]  tx_bit_reg;
  logic [7:0]  tx_shift_reg;
  logic        txd_reg, tx_empty;

  // Popping from STOP chains the next start bit with no idle gap.
  assign tx_pop   = ~fifo_empty &&
                    ((tx_state_reg == S_IDLE) || (tx_state_reg == S_STOP && tx_cnt_reg == 16'd0));
  assign tx_empty = fifo_empty && (tx_state_reg == S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_reg <= S_IDLE;
      tx_cnt_reg   <= 16'd0;
      tx_div_reg   <= 16'(DEFAULT_DIV);
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'd0;
      txd_reg      <= 1'b1;
    end else begin
      case (tx_state_reg)
        S_IDLE: begin
          if (tx_pop) begin
            tx_shift_reg <= fifo_head;
            tx_div_reg   <= baud_reg;
            tx_cnt_reg   <= baud_reg - 16'd1;
            txd_reg      <= 1'b0;
            tx_state_reg <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_reg == 16'd0) begin
            tx_state_reg <= S_DATA;
            tx_cnt_reg   <= tx_div_reg - 16'd1;
            tx_bit_reg   <= 3'd0;
            txd_reg      <= tx_shift_reg[0];
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt_reg == 16'd0) begin
            tx_cnt_reg <= tx_div_reg - 16'd1;
            if (tx_bit_reg == 3'd7) begin
              tx_state_reg <= S_STOP;
              txd_reg      <= 1'b1;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
              txd_reg      <= tx_shift_reg[1];
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        default: begin
          if (tx_cnt_reg == 16'd0) begin
            if (tx_pop) begin
              tx_shift_reg <= fifo_head;
              tx_div_reg   <= baud_reg;
              tx_cnt_reg   <= baud_reg - 16'd1;
              txd_reg      <= 1'b0;
              tx_state_reg <= S_START;
            end else begin
              tx_state_reg <= S_IDLE;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic        rxd_s1_reg, rxd_s2_reg, rxd_s3_reg;
  state_t      rx_state_reg;
  logic [15:0] rx_cnt_reg, rx_div_reg;
  logic [2:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg, rx_byte_reg;
  logic        rx_valid_reg, rx_overrun_reg, rx_frame_err_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rxd_s1_reg <= 1'b1;
      rxd_s2_reg <= 1'b1;
      rxd_s3_reg <= 1'b1;
    end else begin
      rxd_s1_reg <= RXD;
      rxd_s2_reg <= rxd_s1_reg;
      rxd_s3_reg <= rxd_s2_reg;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_reg     <= S_IDLE;
      rx_cnt_reg       <= 16'd0;
      rx_div_reg       <= 16'(DEFAULT_DIV);
      rx_bit_reg       <= 3'd0;
      rx_shift_reg     <= 8'd0;
      rx_byte_reg      <= 8'd0;
      rx_valid_reg     <= 1'b0;
      rx_overrun_reg   <= 1'b0;
      rx_frame_err_reg <= 1'b0;
    end else begin
      // Clears come first so a same-cycle set from the frame logic below wins.
      if (rd_data) rx_valid_reg <= 1'b0;
      if (wr_status && bus.HWDATA[3]) rx_overrun_reg   <= 1'b0;
      if (wr_status && bus.HWDATA[4]) rx_frame_err_reg <= 1'b0;
      case (rx_state_reg)
        S_IDLE: begin
          if (rxd_s3_reg && !rxd_s2_reg) begin
            rx_div_reg   <= baud_reg;
            rx_cnt_reg   <= (baud_reg >> 1) - 16'd1;
            rx_state_reg <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_reg == 16'd0) begin
            if (rxd_s2_reg) begin
              rx_state_reg <= S_IDLE;
            end else begin
              rx_state_reg <= S_DATA;
              rx_cnt_reg   <= rx_div_reg - 16'd1;
              rx_bit_reg   <= 3'd0;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt_reg == 16'd0) begin
            rx_shift_reg <= {rxd_s2_reg, rx_shift_reg[7:1]};
            rx_cnt_reg   <= rx_div_reg - 16'd1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= S_STOP;
            else                    rx_bit_reg   <= rx_bit_reg + 3'd1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        default: begin
          if (rx_cnt_reg == 16'd0) begin
            rx_state_reg <= S_IDLE;
            if (rxd_s2_reg) begin
              if (rx_valid_reg && !rd_data) begin
                rx_overrun_reg <= 1'b1;
              end else begin
                rx_byte_reg  <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
              end
            end else begin
              rx_frame_err_reg <= 1'b1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------- read mux and outputs ----------------
  always_comb begin
    bus.HRDATA = 32'd0;
    if (valid_reg && !write_reg) begin
      case (addr_reg)
        2'd0:    bus.HRDATA = {24'd0, rx_byte_reg};
        2'd1:    bus.HRDATA = {23'd0, tx_ie_reg, 2'b00, tx_drop_reg, rx_frame_err_reg,
                               rx_overrun_reg, rx_valid_reg, tx_empty, fifo_full};
        2'd2:    bus.HRDATA = {16'd0, baud_reg};
        default: bus.HRDATA = 32'd0;
      endcase
    end
  end

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign TXD           = txd_reg;
  assign IRQ           = rx_valid_reg | (tx_empty & tx_ie_reg);
endmodule

// File: tb/tb_ahb_uart.sv
// Directed bench for ahb_uart: TX framing and FIFO overflow, RX delivery/overrun/frame errors,
// baud clamping and mid-frame reset.
module tb_ahb_uart;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RXD = 1'b1;
  logic TXD, IRQ;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] A_DATA   = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h1000_0004;
  localparam logic [31:0] A_BAUD   = 32'h1000_0008;

  ahb_uart_if bus ();

  ahb_uart #(.DEFAULT_DIV(16), .TX_DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus),
    .TXD (TXD),
    .RXD (RXD),
    .IRQ (IRQ)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = 1'b1; bus.HSIZE = 3'b010;
    @(posedge CLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = data;
    @(posedge CLK); #1;
    $display("write %h <= %h", addr, data);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
    @(posedge CLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    data = bus.HRDATA;
    @(posedge CLK); #1;
    $display("read  %h => %h", addr, data);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Waits (bounded) for a start bit, then checks every cycle of the frame against the ideal waveform.
  task automatic sample_frame(input logic [7:0] exp, input int div,
                              output logic [7:0] got, output int bad, output int waited);
    got = 8'd0; bad = 0; waited = 0;
    while (TXD !== 1'b0 && waited < 400) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (TXD !== 1'b0) begin
      bad = -1;
    end else begin
      for (int c = 0; c < 10*div; c++) begin
        logic e;
        if (c < div)        e = 1'b0;
        else if (c < 9*div) e = exp[(c-div)/div];
        else                e = 1'b1;
        if (TXD !== e) bad++;
        if (c >= div && c < 9*div && ((c-div) % div) == div/2) got[(c-div)/div] = TXD;
        @(posedge CLK); #1;
      end
    end
    $display("tx frame %h bad_cycles %0d waited %0d", got, bad, waited);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop, input int div);
    RXD = 1'b0; wait_clk(div);
    for (int i = 0; i < 8; i++) begin RXD = b[i]; wait_clk(div); end
    RXD = stop; wait_clk(div);
    RXD = 1'b1;
    $display("rx frame %h stop %b", b, stop);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_cmp++; if (TXD !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b expected 1", TXD); end
    n_cmp++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
    n_cmp++; if (bus.HRDATA !== 32'd0) begin n_bad++; $display("FAIL reset_hrdata: got %h expected 0", bus.HRDATA); end
    n_cmp++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin n_bad++; $display("FAIL reset_resp: got ready %b resp %b expected 1 0", bus.HREADYOUT, bus.HRESP); end
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL reset_status: got %h expected 00000002", d); end
    ahb_read(A_BAUD, d);
    n_cmp++; if (d !== 32'd16) begin n_bad++; $display("FAIL reset_baud: got %h expected 00000010", d); end
    ahb_read(A_DATA, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", d); end
  endtask

  task automatic test_tx_single();
    logic [7:0] g; int b, w; logic [31:0] d;
    ahb_write(A_DATA, 32'h55);
    sample_frame(8'h55, 16, g, b, w);
    n_cmp++; if (g !== 8'h55) begin n_bad++; $display("FAIL tx55_byte: got %h expected 55", g); end
    n_cmp++; if (b !== 0) begin n_bad++; $display("FAIL tx55_wave: got %0d bad cycles expected 0", b); end
    n_cmp++; if (w !== 1) begin n_bad++; $display("FAIL tx55_latency: got %0d expected 1", w); end
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL tx55_status: got %h expected 00000002", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g; int b, w; logic [31:0] d;
    ahb_write(A_DATA, 32'h30);
    fork
      begin
        for (int i = 0; i < 5; i++) ahb_write(A_DATA, 32'h41 + i);
      end
      begin
        sample_frame(8'h30, 16, g, b, w);
      end
    join
    n_cmp++; if (g !== 8'h30 || b !== 0) begin n_bad++; $display("FAIL b2b_first: got %h/%0d expected 30/0", g, b); end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e8;
      e8 = 8'h41 + 8'(k);
      sample_frame(e8, 16, g, b, w);
      n_cmp++; if (g !== e8 || b !== 0) begin n_bad++; $display("FAIL b2b_frame%0d: got %h/%0d expected %h/0", k, g, b, e8); end
      n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL b2b_gap%0d: got %0d idle cycles expected 0", k, w); end
    end
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h22) begin n_bad++; $display("FAIL b2b_drop: got %h expected 00000022", d); end
    ahb_write(A_STATUS, 32'h20);
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL b2b_drop_clear: got %h expected 00000002", d); end
  endtask

  task automatic test_rx_single();
    logic [31:0] d;
    drive_rx(8'hA3, 1'b1, 16);
    n_cmp++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL rx_irq_set: got %b expected 1", IRQ); end
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL rx_status_valid: got %h expected 00000006", d); end
    ahb_read(A_DATA, d);
    n_cmp++; if (d !== 32'hA3) begin n_bad++; $display("FAIL rx_data: got %h expected 000000a3", d); end
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL rx_status_clear: got %h expected 00000002", d); end
    n_cmp++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL rx_irq_clear: got %b expected 0", IRQ); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    drive_rx(8'h11, 1'b1, 16);
    drive_rx(8'h22, 1'b1, 16);
    ahb_read(A_DATA, d);
    n_cmp++; if (d !== 32'h11) begin n_bad++; $display("FAIL ovr_data: got %h expected 00000011", d); end
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'hA) begin n_bad++; $display("FAIL ovr_status: got %h expected 0000000a", d); end
    ahb_write(A_STATUS, 32'h08);
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL ovr_clear: got %h expected 00000002", d); end
  endtask

  task automatic test_false_start_frame_err();
    logic [31:0] d;
    RXD = 1'b0; wait_clk(6);
    RXD = 1'b1; wait_clk(40);
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL false_start: got %h expected 00000002", d); end
    drive_rx(8'h5A, 1'b0, 16);
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h12) begin n_bad++; $display("FAIL frame_err: got %h expected 00000012", d); end
    n_cmp++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL frame_err_irq: got %b expected 0", IRQ); end
    ahb_write(A_STATUS, 32'h10);
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL frame_err_clear: got %h expected 00000002", d); end
  endtask

  task automatic test_tx_ie();
    logic [31:0] d;
    ahb_write(A_STATUS, 32'h100);
    n_cmp++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL txie_irq: got %b expected 1", IRQ); end
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h102) begin n_bad++; $display("FAIL txie_status: got %h expected 00000102", d); end
    ahb_write(A_STATUS, 32'h0);
    n_cmp++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL txie_off: got %b expected 0", IRQ); end
  endtask

  task automatic test_baud_reset();
    logic [7:0] g; int b, w; logic [31:0] d;
    ahb_write(A_BAUD, 32'd2);
    ahb_read(A_BAUD, d);
    n_cmp++; if (d !== 32'd4) begin n_bad++; $display("FAIL baud_clamp: got %h expected 00000004", d); end
    ahb_write(A_DATA, 32'hC3);
    sample_frame(8'hC3, 4, g, b, w);
    n_cmp++; if (g !== 8'hC3 || b !== 0) begin n_bad++; $display("FAIL baud4_frame: got %h/%0d expected c3/0", g, b); end
    ahb_write(A_DATA, 32'h0F);
    ahb_write(A_DATA, 32'hF0);
    n_cmp++; if (TXD !== 1'b0) begin n_bad++; $display("FAIL pre_reset_txd: got %b expected 0", TXD); end
    #2 RST = 1'b1;
    #1;
    n_cmp++; if (TXD !== 1'b1) begin n_bad++; $display("FAIL async_reset_txd: got %b expected 1", TXD); end
    @(posedge CLK); #1;
    RST = 1'b0;
    wait_clk(2);
    ahb_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL post_reset_status: got %h expected 00000002", d); end
    ahb_read(A_BAUD, d);
    n_cmp++; if (d !== 32'd16) begin n_bad++; $display("FAIL post_reset_baud: got %h expected 00000010", d); end
    b = 0;
    for (int i = 0; i < 20; i++) begin
      if (TXD !== 1'b1) b++;
      @(posedge CLK); #1;
    end
    n_cmp++; if (b !== 0) begin n_bad++; $display("FAIL post_reset_idle: got %0d low cycles expected 0", b); end
  endtask

  initial begin
    bus.HSEL = 1'b0; bus.HADDR = 32'd0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010;
    bus.HWRITE = 1'b0; bus.HWDATA = 32'd0; bus.HREADY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    wait_clk(2);
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_single();
    test_rx_overrun();
    test_false_start_frame_err();
    test_tx_ie();
    test_baud_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_uart.md
Name: ahb_uart

Overview:
- AHB-Lite slave UART on the urv_cpu data bus, decoded at 0x1000_0000.
- Replaces the bench-side console write hack.
- Serialises bytes written by the CPU onto TXD through a 4-entry TX FIFO.
- Receives 8N1 frames from RXD into a single holding register.
- Exposes status and a programmable baud divisor.

Parameters:
- DEFAULT_DIV, 16: reset value of BAUD register, in clocks per bit.
- TX_DEPTH, 4: TX FIFO entries (power of two).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active high
- HSEL  in  1  slave select
- HADDR  in  32  byte address; only [3:2] decoded
- HTRANS  in  2  transfer type; transfer valid when HTRANS[1]=1
- HSIZE  in  3  ignored; all accesses treated as word
- HWRITE  in  1  write when 1
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  bus-wide ready; address phase accepted only when 1
- HREADYOUT  out  1  constant 1 (zero wait states)
- HRDATA  out  32  read data, valid in data phase
- HRESP  out  1  constant 0 (OKAY)
- TXD  out  1  serial out, idle high
- RXD  in  1  serial in, asynchronous, idle high
- IRQ  out  1  level: rx_valid or (tx_empty and tx_ie)

Behaviour:
- Registers, by HADDR[3:2]:
  - 0 DATA: write pushes HWDATA[7:0] to TX FIFO; read returns {24'b0, rx_byte} and clears rx_valid.
  - 1 STATUS, read: bit0 tx_full, bit1 tx_empty (FIFO empty and shifter idle), bit2 rx_valid, bit3 rx_overrun, bit4 rx_frame_err, bit5 tx_drop, bit8 tx_ie.
  - 1 STATUS, write: 1 to bits 3/4/5 clears that sticky flag; bit8 is stored as tx_ie.
  - 2 BAUD: [15:0] clocks per bit; writes below 4 store 4.
  - 3: reads 0; writes ignored.
- Bus timing:
  - Address phase (HSEL & HTRANS[1] & HREADY) registers addr, write flag and valid.
  - Write takes effect on the clock ending the data phase.
  - HRDATA is combinational from the registered address during the data phase; it is 0 when no transfer is valid.
  - Read-side effects (rx_valid clear) occur on the clock ending the data phase.
- TX FIFO:
  - Push when full: byte discarded, tx_drop set.
  - Push and shifter pop in the same cycle are both honoured.
  - Pointers wrap modulo TX_DEPTH; full and empty are distinguished by an extra pointer bit.
- TX FSM IDLE -> START -> DATA -> STOP -> IDLE:
  - Leaves IDLE when FIFO non-empty; pops one byte.
  - Each state lasts BAUD clocks; DATA covers 8 bits, LSB first.
  - From STOP, goes directly to START if FIFO non-empty (back-to-back frames, no extra idle).
  - BAUD is sampled at frame start; mid-frame BAUD writes apply to the next frame.
- RX path:
  - RXD double-flop synchronised (2-cycle latency).
  - FSM IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: synced falling edge starts the counter.
  - START: sample at BAUD/2; if high, false start, return to IDLE.
  - DATA: sample every BAUD clocks, LSB first.
  - STOP: sample once. If 1, byte is delivered; if 0, rx_frame_err is set and the byte is discarded.
  - Delivery while rx_valid=1: rx_overrun set, old byte kept.
  - Delivery in the same cycle as a DATA read: new byte loaded, rx_valid stays 1, no overrun.
  - Returns to IDLE right after the STOP sample; a new start edge is accepted immediately.
- Reset values:
  - TXD=1, HRDATA=0, IRQ=0.
  - FIFO empty, all flags 0, tx_ie=0, BAUD=DEFAULT_DIV, both FSMs IDLE.
  - Reset mid-frame forces TXD=1 asynchronously and abandons both frames.

Test Plan:
- Reset, BAUD=16; write DATA=0x55 -> TXD low 16 clk, then bits 1,0,1,0,1,0,1,0 at 16 clk each, then high 16 clk; STATUS reads 0x2 afterwards.
- Write 0x41,0x42,0x43,0x44,0x45 back-to-back while first frame sends -> 0x41..0x44 sent contiguously (4 × 160 clk, no idle gap); 0x45 dropped; STATUS bit5=1; writing STATUS=0x20 clears it.
- Drive RXD frame 0xA3 at 16 clk/bit -> STATUS bit2=1, IRQ=1; read DATA=0x000000A3; STATUS bit2=0, IRQ=0.
- Two RX frames 0x11 then 0x22 without a read -> DATA reads 0x11, STATUS bit3=1.
- RXD low pulse of 6 clk, then stop bit driven 0 on a full frame -> first: no byte, no flags; second: bit4=1, rx_valid=0.
- Write BAUD=2 -> reads 4; assert RST mid TX frame -> TXD=1 in the same cycle; FIFO empty; BAUD=16.
